// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// funct3 encodings for loads/stores and the fault codes returned to the core.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  // Doubleword sizes exist only on RV64; stores have no unsigned variants.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic wen,
                                      input logic is64);
    logic ill;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ill = 1'b0;
      F3_D, F3_WU:                    ill = !is64;
      default:                        ill = 1'b1;
    endcase
    return ill || (wen && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: access checks, bus address, byte-lane
// mask and shifted store data on the request side; load extraction on the response side.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                          wen_i,
  input  logic [2:0]                    func3_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [XLEN-1:0]               wdata_i,
  output logic [1:0]                    err_o,
  output logic [ADDR_W-1:0]             baddr_o,
  output logic [XLEN/8-1:0]             wmask_o,
  output logic [XLEN-1:0]               wdata_o,
  input  logic [2:0]                    ld_func3_i,
  input  logic [$clog2(XLEN/8)-1:0]     ld_off_i,
  input  logic [XLEN-1:0]               rdata_i,
  output logic [XLEN-1:0]               ld_data_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  logic [1:0]       size_log;
  logic [2:0]       amask;
  logic             misalign;
  logic [OFF_W-1:0] off;
  logic [NB-1:0]    bmask;

  // funct3[1:0] is log2 of the access size in bytes for every encoding.
  assign size_log = func3_i[1:0];
  assign off      = addr_i[OFF_W-1:0];

  always_comb begin
    case (size_log)
      2'd0:    amask = 3'b000;
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
    misalign = |(addr_i[2:0] & amask);
    if (f3_illegal(func3_i, wen_i, XLEN == 64)) begin
      err_o = ERR_ILLEGAL;
    end else if (misalign) begin
      err_o = ERR_MISALIGN;
    end else begin
      err_o = ERR_OK;
    end
  end

  always_comb begin
    baddr_o = addr_i;
    baddr_o[OFF_W-1:0] = '0;
  end

  always_comb begin
    bmask = '0;
    for (int i = 0; i < NB; i++) begin
      bmask[i] = (i < (1 << size_log));
    end
    wmask_o = wen_i ? (bmask << off) : '0;
    wdata_o = wdata_i << {off, 3'b000};
  end

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] keep;
  logic            sbit;

  always_comb begin
    sh   = rdata_i >> {ld_off_i, 3'b000};
    keep = '0;
    for (int i = 0; i < XLEN; i++) begin
      keep[i] = (i < (8 << ld_func3_i[1:0]));
    end
    case (ld_func3_i[1:0])
      2'd0:    sbit = sh[7];
      2'd1:    sbit = sh[15];
      2'd2:    sbit = sh[31];
      default: sbit = sh[XLEN-1];
    endcase
    sbit      = sbit & !ld_func3_i[2];
    ld_data_o = (sh & keep) | ({XLEN{sbit}} & ~keep);
  end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one request at a time, IDLE -> REQ -> WAIT -> RESP,
// with faulting accesses short-circuited straight to RESP without memory traffic.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_func3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_rdata,
  output logic [1:0]          resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_e        state_q, state_d;
  logic [2:0]        func3_q, func3_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              mreq_vld_q, mreq_vld_d;
  logic              mreq_wen_q, mreq_wen_d;
  logic [ADDR_W-1:0] mreq_addr_q, mreq_addr_d;
  logic [XLEN-1:0]   mreq_wdata_q, mreq_wdata_d;
  logic [NB-1:0]     mreq_wmask_q, mreq_wmask_d;
  logic              resp_vld_q, resp_vld_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q, resp_err_d;

  logic [1:0]        chk_err;
  logic [ADDR_W-1:0] baddr;
  logic [NB-1:0]     wmask;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   ld_data;

  lsu_align #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_align (
    .wen_i      (req_wen),
    .func3_i    (req_func3),
    .addr_i     (req_addr),
    .wdata_i    (req_wdata),
    .err_o      (chk_err),
    .baddr_o    (baddr),
    .wmask_o    (wmask),
    .wdata_o    (wdata_sh),
    .ld_func3_i (func3_q),
    .ld_off_i   (off_q),
    .rdata_i    (mem_rsp_rdata),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    func3_d      = func3_q;
    off_d        = off_q;
    mreq_vld_d   = mreq_vld_q;
    mreq_wen_d   = mreq_wen_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_wdata_d = mreq_wdata_q;
    mreq_wmask_d = mreq_wmask_q;
    resp_vld_d   = resp_vld_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          func3_d = req_func3;
          off_d   = req_addr[OFF_W-1:0];
          if (chk_err != ERR_OK) begin
            resp_vld_d   = 1'b1;
            resp_err_d   = chk_err;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else begin
            mreq_vld_d   = 1'b1;
            mreq_wen_d   = req_wen;
            mreq_addr_d  = baddr;
            mreq_wdata_d = wdata_sh;
            mreq_wmask_d = wmask;
            state_d      = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          mreq_vld_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          resp_vld_d   = 1'b1;
          resp_err_d   = ERR_OK;
          resp_rdata_d = mreq_wen_q ? '0 : ld_data;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_vld_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      func3_q      <= '0;
      off_q        <= '0;
      mreq_vld_q   <= 1'b0;
      mreq_wen_q   <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
      mreq_wmask_q <= '0;
      resp_vld_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
    end else begin
      state_q      <= state_d;
      func3_q      <= func3_d;
      off_q        <= off_d;
      mreq_vld_q   <= mreq_vld_d;
      mreq_wen_q   <= mreq_wen_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
      mreq_wmask_q <= mreq_wmask_d;
      resp_vld_q   <= resp_vld_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = mreq_vld_q;
  assign mem_req_wen   = mreq_wen_q;
  assign mem_req_addr  = mreq_addr_q;
  assign mem_req_wdata = mreq_wdata_q;
  assign mem_req_wmask = mreq_wmask_q;
  assign resp_valid    = resp_vld_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;

endmodule
